// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - sequential 8-bit restoring divider built on one adder8 in subtract mode
// Defining DIV8_SIGNED_EN adds the signed_op port and two's-complement division.
module adder8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       carry_i,
   output logic [7:0] y_o,
   output logic       carry_o
);
   assign {carry_o, y_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, carry_i};
endmodule

module div8_seq #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
`ifdef DIV8_SIGNED_EN
   input  logic       signed_op,
`endif
   output logic       busy,
   output logic       done,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       div_by_zero
);
   if (WIDTH != 8) begin : g_width_check
      $fatal(1, "div8_seq: WIDTH must be 8");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t     state_q;
   logic [7:0] q_q, d_q, r_q, quot_q, rem_q;
   logic [2:0] cnt_q;
   logic       busy_q, done_q, dbz_q, neg_quo_q, neg_rem_q;

   logic [7:0] s, diff, q_d, r_d, quot_d, rem_d, dvd_mag, dsr_mag;
   logic       no_borrow, neg_quo_in, neg_rem_in;

   // Trial subtraction S - D as S + ~D + 1; carry out set means no borrow, i.e. S >= D.
   assign s = {r_q[6:0], q_q[7]};

   adder8 u_sub (
      .a_i     (s),
      .b_i     (~d_q),
      .carry_i (1'b1),
      .y_o     (diff),
      .carry_o (no_borrow)
   );

   assign q_d    = {q_q[6:0], no_borrow};
   assign r_d    = no_borrow ? diff : s;
   assign quot_d = neg_quo_q ? (~q_d + 8'd1) : q_d;
   assign rem_d  = neg_rem_q ? (~r_d + 8'd1) : r_d;

`ifdef DIV8_SIGNED_EN
   assign dvd_mag    = (signed_op && dividend[7]) ? (~dividend + 8'd1) : dividend;
   assign dsr_mag    = (signed_op && divisor[7])  ? (~divisor + 8'd1)  : divisor;
   assign neg_quo_in = signed_op & (dividend[7] ^ divisor[7]);
   assign neg_rem_in = signed_op & dividend[7];
`else
   assign dvd_mag    = dividend;
   assign dsr_mag    = divisor;
   assign neg_quo_in = 1'b0;
   assign neg_rem_in = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         q_q       <= 8'd0;
         d_q       <= 8'd0;
         r_q       <= 8'd0;
         cnt_q     <= 3'd0;
         quot_q    <= 8'd0;
         rem_q     <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  q_q       <= dvd_mag;
                  d_q       <= dsr_mag;
                  r_q       <= 8'd0;
                  cnt_q     <= 3'd7;
                  neg_quo_q <= neg_quo_in;
                  neg_rem_q <= neg_rem_in;
                  busy_q    <= 1'b1;
                  if (divisor == 8'd0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     quot_q  <= 8'hFF;
                     rem_q   <= dividend;
                     dbz_q   <= 1'b1;
                  end else begin
                     state_q <= CALC;
                     dbz_q   <= 1'b0;
                  end
               end
            end
            CALC: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  quot_q  <= quot_d;
                  rem_q   <= rem_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div8_seq.sv
// tb/tb_div8_seq.sv - self-checking bench for div8_seq with an arithmetic reference model
module tb_div8_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [7:0] divisor = 8'd0;
`ifdef DIV8_SIGNED_EN
   logic       signed_op = 1'b0;
`endif
   logic       busy, done, div_by_zero;
   logic [7:0] quotient, remainder;

   div8_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef DIV8_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: cycles remaining until the divider is free again, results from / and %.
   int         remaining = 0;
   int         sa, sb;
   logic       m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   logic [7:0] m_q = 8'd0, m_r = 8'd0, p_q = 8'd0, p_r = 8'd0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_dbz  = 1'b0;
         m_q    = 8'd0;
         m_r    = 8'd0;
      end else begin
         m_done = 1'b0;
         if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
               m_busy = 1'b0;
            end else if (remaining == 1) begin
               m_done = 1'b1;
               m_q    = p_q;
               m_r    = p_r;
            end
         end else if (start) begin
            m_busy = 1'b1;
            m_dbz  = 1'b0;
            if (divisor == 8'd0) begin
               m_q       = 8'hFF;
               m_r       = dividend;
               m_dbz     = 1'b1;
               m_done    = 1'b1;
               remaining = 1;
            end else begin
               sa = int'(dividend);
               sb = int'(divisor);
`ifdef DIV8_SIGNED_EN
               if (signed_op) begin
                  sa = int'($signed(dividend));
                  sb = int'($signed(divisor));
               end
`endif
               p_q       = 8'(sa / sb);
               p_r       = 8'(sa % sb);
               remaining = 9;
            end
         end
      end
   end

   logic armed = 1'b0;

   always @(negedge clk) begin
      if (armed && !rst) begin
         check("busy", int'(busy), int'(m_busy));
         check("done", int'(done), int'(m_done));
         check("div_by_zero", int'(div_by_zero), int'(m_dbz));
         check("quotient", int'(quotient), int'(m_q));
         check("remainder", int'(remainder), int'(m_r));
      end
   end

   task automatic do_start(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_cyc, input int cyc0);
      int cyc = cyc0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({name, " latency"}, cyc, exp_cyc);
   endtask

   task automatic check_result(input string name, input int q, input int r, input int z);
      check({name, " quotient"}, int'(quotient), q);
      check({name, " remainder"}, int'(remainder), r);
      check({name, " div_by_zero"}, int'(div_by_zero), z);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      rst   = 1'b0;
      armed = 1'b1;

      do_start(8'd100, 8'd7);
      check("100/7 busy after accept", int'(busy), 1);
      wait_done("100/7", 9, 1);
      check_result("100/7", 14, 2, 0);
      @(negedge clk);
      check("100/7 done falls", int'(done), 0);

      do_start(8'd255, 8'd16);
      wait_done("255/16", 9, 1);
      check_result("255/16", 15, 15, 0);
      repeat (3) @(negedge clk);
      check("255/16 hold quotient", int'(quotient), 15);
      check("255/16 hold remainder", int'(remainder), 15);
      do_start(8'd5, 8'd8);
      wait_done("5/8", 9, 1);
      check_result("5/8", 0, 5, 0);

      do_start(8'd37, 8'd0);
      wait_done("37/0", 1, 1);
      check_result("37/0", 255, 37, 1);
      @(negedge clk);
      check("37/0 done falls", int'(done), 0);
      do_start(8'd9, 8'd3);
      wait_done("9/3", 9, 1);
      check_result("9/3", 3, 0, 0);

      @(negedge clk);
      dividend = 8'd200;
      divisor  = 8'd3;
      start    = 1'b1;
      @(negedge clk);
      check("200/3 busy", int'(busy), 1);
      repeat (2) @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd5;
      wait_done("200/3 held", 9, 3);
      check_result("200/3 held", 66, 2, 0);
      @(negedge clk);
      check("held start idle gap", int'(busy), 0);
      @(negedge clk);
      check("held start retrigger", int'(busy), 1);
      start = 1'b0;
      wait_done("50/5 retrigger", 9, 1);
      check_result("50/5 retrigger", 10, 0, 0);

      do_start(8'd250, 8'd9);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort quotient", int'(quotient), 0);
      check("abort remainder", int'(remainder), 0);
      @(negedge clk);
      rst = 1'b0;
      do_start(8'd250, 8'd9);
      wait_done("250/9", 9, 1);
      check_result("250/9", 27, 7, 0);

`ifdef DIV8_SIGNED_EN
      signed_op = 1'b1;
      do_start(8'h9C, 8'd7);
      wait_done("-100/7", 9, 1);
      check_result("-100/7", 8'hF2, 8'hFE, 0);
      do_start(8'h80, 8'hFF);
      wait_done("-128/-1", 9, 1);
      check_result("-128/-1", 8'h80, 0, 0);
      signed_op = 1'b0;
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/div8_seq.md
Name: div8_seq

Overview:
- Sequential unsigned 8-bit restoring divider built around one adder8 instance used permanently in subtract mode.
- Sits directly upstream of adder8: drives its a/b operands with carry_in tied to 1 (a - b), and consumes its y result and carry (no-borrow) output on every iteration.
- One quotient bit per clock; start/busy/done handshake towards the controlling logic.

Parameters:
- WIDTH, 8, operand width. Only 8 is legal because of the adder8 instance. Any other value must trigger $fatal at elaboration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  8  unsigned dividend, captured when start is accepted.
- divisor  input  8  unsigned divisor, captured when start is accepted.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  8  result quotient.
- remainder  output  8  result remainder.
- div_by_zero  output  1  set when the captured divisor was 0.

Behaviour:
- Reset: async; state=IDLE and all outputs/registers = 0. Reset mid-CALC aborts immediately and leaves no partial result.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge captures the operands. Q := dividend, D := divisor, R := 0, cnt := 7, div_by_zero := 0.
  - Then go to CALC, or directly to DONE if divisor==0.
- Divide by zero: quotient := 8'hFF, remainder := dividend, div_by_zero := 1, done one cycle after accept.
- CALC, one iteration per edge:
  - Shifted remainder S = {R[6:0], Q[7]}; Q shifts left.
  - adder8 computes a=S, b=D, carry_in=1. carry=1 means S >= D.
  - If carry=1: R := y and Q[0] := 1. Else R := S and Q[0] := 0.
  - cnt decrements; after the iteration at cnt==0, go to DONE.
  - S never exceeds 8 bits: pre-shift R < 2^k after k steps, so the 8-bit trial is sufficient.
- DONE: done=1 for exactly one cycle; quotient=Q, remainder=R registered. Next edge returns to IDLE.
- Latency: accept at edge 0, iterations at edges 1..8, DONE state after edge 8, IDLE after edge 9.
- quotient/remainder/div_by_zero hold their values from DONE until the next accepted start.
- start while busy (CALC or DONE) is ignored with no queuing. start held continuously re-triggers in IDLE, i.e. every 10 cycles.
- All arithmetic is unsigned modulo 256. The adder8 carry output is the only comparison source; there is no separate comparator.

Optional Feature:
- DIV8_SIGNED_EN defined:
  - Adds input port signed_op (1 bit), captured at accept.
  - When signed_op=1, operands are two's-complement. Magnitudes (|-128| = 128) are formed at capture.
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder takes the dividend's sign. Both are negated combinationally on the DONE transition, with latency unchanged.
  - -128 / -1 gives quotient 8'h80, remainder 0.
  - Divide by zero gives quotient 8'hFF and remainder = raw dividend, in both modes.
- Not defined: no signed_op port; purely unsigned behaviour as above.

Test Plan:
- 100/7, start pulse -> busy rises next cycle; done on the 9th cycle after accept with quotient=14, remainder=2, div_by_zero=0; done low the following cycle.
- 255/16 -> quotient=15, remainder=15. Then 5/8 -> quotient=0, remainder=5. Outputs hold between runs.
- 37/0 -> done one cycle after accept, quotient=8'hFF, remainder=37, div_by_zero=1. A following 9/3 clears div_by_zero; quotient=3, remainder=0.
- Start 200/3 with start held high throughout -> single result 66 r2. The second operand set applied during busy is ignored. A new run begins only after return to IDLE.
- Assert rst at the 4th CALC cycle of 250/9 -> busy, done, quotient, remainder all 0 immediately (asynchronously). Then 250/9 -> 27 r7.
- With DIV8_SIGNED_EN and signed_op=1:
  - -100/7 -> quotient 8'hF2 (-14), remainder 8'hFE (-2).
  - -128/-1 -> quotient 8'h80, remainder 0.
